// File: rtl/shift_unit_pkg.sv
// Shared shift-unit definitions: command encodings, count-field layout and FSM states.
// Encodings follow the low three opcode bits of the ASH/ROT/LSH/ASHC/ROTC/LSHC group.
package shift_unit_pkg;

    typedef enum logic [2:0] {
        CMD_ASH  = 3'd0,
        CMD_ROT  = 3'd1,
        CMD_LSH  = 3'd2,
        CMD_ASHC = 3'd4,
        CMD_ROTC = 3'd5,
        CMD_LSHC = 3'd6
    } shift_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_e;

    localparam int COUNT_WIDTH    = 9;
    localparam int COUNT_MAG_BITS = 8;
    localparam int STEP_AMT_WIDTH = 4;

    // Storage index of the count sign bit, which sits at big-endian bit position WORDSIZE/2.
    function automatic int count_sign_pos(input int wordsize);
        return wordsize - 1 - wordsize / 2;
    endfunction

endpackage

// File: rtl/shift_unit_step.sv
// Combinational single step: shifts hi/lo by up to STEP positions for any shift command
// and reports whether an arithmetic left shift pushed a non-sign bit out of bit 1.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WORDSIZE = 36,
    parameter int STEP     = 1
) (
    input  shift_cmd_e                cmd,
    input  logic                      left,
    input  logic [STEP_AMT_WIDTH-1:0] amount,
    input  logic [WORDSIZE-1:0]       hi_in,
    input  logic [WORDSIZE-1:0]       lo_in,
    output logic [WORDSIZE-1:0]       hi_out,
    output logic [WORDSIZE-1:0]       lo_out,
    output logic                      ovf
);

    localparam int W = WORDSIZE;

    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         sign;

    // Storage is little-endian: big-endian bit 0 (the sign) lives at index W-1.
    always_comb begin
        hi   = hi_in;
        lo   = lo_in;
        ovf  = 1'b0;
        sign = hi_in[W-1];
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(amount)) begin
                case (cmd)
                    CMD_LSH:  hi = left ? {hi[W-2:0], 1'b0} : {1'b0, hi[W-1:1]};
                    CMD_ROT:  hi = left ? {hi[W-2:0], hi[W-1]} : {hi[0], hi[W-1:1]};
                    CMD_ASH: begin
                        if (left) begin
                            ovf = ovf | (hi[W-2] ^ sign);
                            hi  = {sign, hi[W-3:0], 1'b0};
                        end else begin
                            hi  = {sign, sign, hi[W-2:1]};
                        end
                    end
                    CMD_LSHC: begin
                        if (left) {hi, lo} = {hi[W-2:0], lo, 1'b0};
                        else      {hi, lo} = {1'b0, hi, lo[W-1:1]};
                    end
                    CMD_ROTC: begin
                        if (left) {hi, lo} = {hi[W-2:0], lo, hi[W-1]};
                        else      {hi, lo} = {lo[0], hi, lo[W-1:1]};
                    end
                    CMD_ASHC: begin
                        if (left) begin
                            ovf      = ovf | (hi[W-2] ^ sign);
                            {hi, lo} = {sign, hi[W-3:0], lo[W-2], sign, lo[W-3:0], 1'b0};
                        end else begin
                            {hi, lo} = {sign, sign, hi[W-2:1], sign, hi[0], lo[W-2:1]};
                        end
                    end
                    default: begin
                        hi = hi;
                        lo = lo;
                    end
                endcase
            end
        end
        hi_out = hi;
        lo_out = lo;
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter for single- and double-word logical, rotate and arithmetic shifts,
// moving at most STEP positions per clock until the latched count is exhausted.
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WORDSIZE = 36,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [2:0]          command,
    input  logic [WORDSIZE-1:0] op1,
    input  logic [WORDSIZE-1:0] op1low,
    input  logic [WORDSIZE-1:0] op2,
    output logic                busy,
    output logic                done,
    output logic [WORDSIZE-1:0] result,
    output logic [WORDSIZE-1:0] resultlow,
    output logic                overflow
);

    localparam int                       SIGN_POS = count_sign_pos(WORDSIZE);
    localparam logic [COUNT_WIDTH-1:0]   STEP_CNT = COUNT_WIDTH'(STEP);
    localparam logic [STEP_AMT_WIDTH-1:0] STEP_AMT = STEP_AMT_WIDTH'(STEP);

    shift_state_e              state;
    shift_state_e              next_state;
    shift_cmd_e                cmd_q;
    logic                      left_q;
    logic [COUNT_WIDTH-1:0]    remaining;
    logic [WORDSIZE-1:0]       hi_q;
    logic [WORDSIZE-1:0]       lo_q;
    logic                      ovf_q;

    logic [COUNT_WIDTH-1:0]    count_raw;
    logic [COUNT_WIDTH-1:0]    count_mag;
    logic                      accept;
    logic [STEP_AMT_WIDTH-1:0] step_amt;
    logic [WORDSIZE-1:0]       step_hi;
    logic [WORDSIZE-1:0]       step_lo;
    logic                      step_ovf;
    logic                      op2_unused;

    assign op2_unused = ^op2;

    // A count of -256 has magnitude 256, which still fits the 9-bit remaining counter.
    assign count_raw = {op2[SIGN_POS], op2[COUNT_MAG_BITS-1:0]};
    assign count_mag = count_raw[COUNT_WIDTH-1] ? (~count_raw + 9'd1) : count_raw;
    assign accept    = (state == ST_IDLE) && start && !abort;
    assign step_amt  = (remaining >= STEP_CNT) ? STEP_AMT : remaining[STEP_AMT_WIDTH-1:0];

    shift_step #(
        .WORDSIZE (WORDSIZE),
        .STEP     (STEP)
    ) u_step (
        .cmd    (cmd_q),
        .left   (left_q),
        .amount (step_amt),
        .hi_in  (hi_q),
        .lo_in  (lo_q),
        .hi_out (step_hi),
        .lo_out (step_lo),
        .ovf    (step_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = (count_mag == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort)                      next_state = ST_IDLE;
                else if (remaining <= STEP_CNT) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

    // Working registers double as the visible result, so they hold after DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= CMD_LSH;
            left_q    <= 1'b0;
            remaining <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            cmd_q     <= shift_cmd_e'(command);
            left_q    <= ~count_raw[COUNT_WIDTH-1];
            remaining <= count_mag;
            hi_q      <= op1;
            lo_q      <= op1low;
            ovf_q     <= 1'b0;
        end else if (state == ST_SHIFT && !abort) begin
            hi_q      <= step_hi;
            lo_q      <= step_lo;
            ovf_q     <= ovf_q | step_ovf;
            remaining <= remaining - COUNT_WIDTH'(step_amt);
        end
    end

    assign result    = hi_q;
    assign resultlow = lo_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: one STEP=1 and one STEP=4 instance share the same stimulus.
module tb_shift_unit;
    import shift_unit_pkg::*;

    localparam int W = 36;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         abort;
    logic [2:0]   command;
    logic [W-1:0] op1;
    logic [W-1:0] op1low;
    logic [W-1:0] op2;

    logic         busy1, done1, ovf1;
    logic [W-1:0] res1, reslow1;
    logic         busy4, done4, ovf4;
    logic [W-1:0] res4, reslow4;

    int test_count = 0;
    int fail_count = 0;
    int dc1, dc4;
    logic seen_done;

    always #5 clk = ~clk;

    shift_unit #(.WORDSIZE(W), .STEP(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .command(command),
        .op1(op1), .op1low(op1low), .op2(op2), .busy(busy1), .done(done1),
        .result(res1), .resultlow(reslow1), .overflow(ovf1)
    );

    shift_unit #(.WORDSIZE(W), .STEP(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .command(command),
        .op1(op1), .op1low(op1low), .op2(op2), .busy(busy4), .done(done4),
        .result(res4), .resultlow(reslow4), .overflow(ovf4)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0o expected=%0o", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start; returns at the negedge of cycle 1 (start sampled at edge 0).
    task automatic applyStimulus(input logic [2:0] cmd, input logic [W-1:0] a,
                                 input logic [W-1:0] a_low, input logic [W-1:0] b);
        @(negedge clk);
        command = cmd;
        op1     = a;
        op1low  = a_low;
        op2     = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input int max_cycles, output int c1, output int c4);
        c1 = -1;
        c4 = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            if (done1 && c1 < 0) c1 = c;
            if (done4 && c4 < 0) c4 = c;
            if (c1 >= 0 && c4 >= 0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        command = CMD_LSH;
        op1     = '0;
        op1low  = '0;
        op2     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", W'(busy1), W'(0));
        checkOutput("reset_done", W'(done1), W'(0));
        checkOutput("reset_result", res1, '0);
        checkOutput("reset_resultlow", reslow1, '0);
        checkOutput("reset_overflow", W'(ovf1), W'(0));
        reset_n = 1'b1;

        applyStimulus(CMD_LSH, 36'o1, 36'o0, 36'o3);
        checkOutput("lsh3_busy", W'(busy1), W'(1));
        waitDone(20, dc1, dc4);
        checkOutput("lsh3_done_cycle", W'(dc1), W'(4));
        checkOutput("lsh3_done_cycle_s4", W'(dc4), W'(2));
        checkOutput("lsh3_result", res1, 36'o10);
        checkOutput("lsh3_result_s4", res4, 36'o10);
        checkOutput("lsh3_overflow", W'(ovf1), W'(0));

        applyStimulus(CMD_ASH, 36'o200000000000, 36'o0, 36'o1);
        waitDone(20, dc1, dc4);
        checkOutput("ash_ovf_done_cycle", W'(dc1), W'(2));
        checkOutput("ash_ovf_result", res1, 36'o0);
        checkOutput("ash_ovf_overflow", W'(ovf1), W'(1));
        checkOutput("ash_ovf_overflow_s4", W'(ovf4), W'(1));

        applyStimulus(CMD_ASH, 36'o400000000000, 36'o0, 36'o000000400335);
        waitDone(60, dc1, dc4);
        checkOutput("ash_r35_done_cycle", W'(dc1), W'(36));
        checkOutput("ash_r35_done_cycle_s4", W'(dc4), W'(10));
        checkOutput("ash_r35_result", res1, 36'o777777777777);
        checkOutput("ash_r35_result_s4", res4, 36'o777777777777);
        checkOutput("ash_r35_overflow", W'(ovf1), W'(0));

        applyStimulus(CMD_ROTC, 36'o0, 36'o1, 36'o000000400377);
        waitDone(20, dc1, dc4);
        checkOutput("rotc_r1_done_cycle", W'(dc1), W'(2));
        checkOutput("rotc_r1_result", res1, 36'o400000000000);
        checkOutput("rotc_r1_resultlow", reslow1, 36'o0);

        applyStimulus(CMD_LSHC, 36'o1, 36'o200000000000, 36'o1);
        waitDone(20, dc1, dc4);
        checkOutput("lshc_l1_result", res1, 36'o2);
        checkOutput("lshc_l1_resultlow", reslow1, 36'o400000000000);

        applyStimulus(CMD_ASHC, 36'o1, 36'o200000000000, 36'o1);
        waitDone(20, dc1, dc4);
        checkOutput("ashc_l1_result", res1, 36'o3);
        checkOutput("ashc_l1_resultlow", reslow1, 36'o0);
        checkOutput("ashc_l1_overflow", W'(ovf1), W'(0));

        applyStimulus(CMD_ASHC, 36'o400000000000, 36'o1, 36'o000000400376);
        waitDone(20, dc1, dc4);
        checkOutput("ashc_r2_result", res1, 36'o700000000000);
        checkOutput("ashc_r2_resultlow", reslow1, 36'o400000000000);
        checkOutput("ashc_r2_result_s4", res4, 36'o700000000000);

        applyStimulus(CMD_ROT, 36'o400000000001, 36'o0, 36'o1);
        waitDone(20, dc1, dc4);
        checkOutput("rot_l1_result", res1, 36'o3);

        applyStimulus(CMD_ASH, 36'o700000000000, 36'o0, 36'o1);
        waitDone(20, dc1, dc4);
        checkOutput("ash_neg_l1_result", res1, 36'o600000000000);
        checkOutput("ash_neg_l1_overflow", W'(ovf1), W'(0));

        // Counts at or beyond the word width still run the full latency.
        applyStimulus(CMD_LSH, 36'o777777777777, 36'o0, 36'o50);
        waitDone(60, dc1, dc4);
        checkOutput("lsh40_done_cycle", W'(dc1), W'(41));
        checkOutput("lsh40_done_cycle_s4", W'(dc4), W'(11));
        checkOutput("lsh40_result", res1, 36'o0);

        applyStimulus(CMD_LSH, 36'o777777777777, 36'o0, 36'o000000400000);
        waitDone(300, dc1, dc4);
        checkOutput("lsh_r256_done_cycle", W'(dc1), W'(257));
        checkOutput("lsh_r256_done_cycle_s4", W'(dc4), W'(65));
        checkOutput("lsh_r256_result", res1, 36'o0);

        // Start coinciding with done must be dropped.
        applyStimulus(CMD_LSH, 36'o5, 36'o0, 36'o1);
        @(negedge clk);
        checkOutput("coincide_done", W'(done1), W'(1));
        start = 1'b1;
        op1   = 36'o7;
        op2   = 36'o0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("coincide_no_done", W'(done1), W'(0));
        checkOutput("coincide_no_busy", W'(busy1), W'(0));
        checkOutput("coincide_result", res1, 36'o12);

        applyStimulus(CMD_LSH, 36'o1, 36'o0, 36'o144);
        seen_done = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            start = (c == 5);
            abort = (c == 20);
            if (c == 5) begin
                op1 = 36'o777777777777;
                op2 = 36'o3;
            end
            if (done1 || done4) seen_done = 1'b1;
            if (c == 20) checkOutput("abort_busy_before", W'(busy1), W'(1));
            if (c == 21) begin
                checkOutput("abort_busy_dropped", W'(busy1), W'(0));
                checkOutput("abort_busy_dropped_s4", W'(busy4), W'(0));
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_no_done", W'(seen_done), W'(0));

        applyStimulus(CMD_LSH, 36'o1, 36'o0, 36'o3);
        waitDone(20, dc1, dc4);
        checkOutput("post_abort_done_cycle", W'(dc1), W'(4));
        checkOutput("post_abort_result", res1, 36'o10);

        applyStimulus(CMD_ROT, 36'o123, 36'o0, 36'o62);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midop_reset_busy", W'(busy1), W'(0));
        checkOutput("midop_reset_done", W'(done1), W'(0));
        checkOutput("midop_reset_result", res1, '0);
        checkOutput("midop_reset_resultlow", reslow1, '0);
        checkOutput("midop_reset_overflow", W'(ovf1), W'(0));
        checkOutput("midop_reset_busy_s4", W'(busy4), W'(0));
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(CMD_LSH, 36'o555, 36'o0, 36'o0);
        waitDone(20, dc1, dc4);
        checkOutput("count0_done_cycle", W'(dc1), W'(1));
        checkOutput("count0_done_cycle_s4", W'(dc4), W'(1));
        checkOutput("count0_result", res1, 36'o555);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
